// File: rtl/bitrev_unscramble.sv
// Ping-pong reorder buffer: bit-reversed frame in, natural order out, flow-controlled on both sides.
// Optional last_o flag on the final natural-order sample is enabled by defining BITREV_UNSCR_LAST_EN.
module bitrev_unscramble #(
    parameter int K  = 10,
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          valid_i,
    input  logic [DW-1:0] data_i,
    output logic          ready_o,
    output logic          valid_o,
    output logic [DW-1:0] data_o,
    input  logic          ready_i
`ifdef BITREV_UNSCR_LAST_EN
    ,
    output logic          last_o
`endif
);

    localparam int         N        = 1 << K;
    localparam logic [K-1:0] CNT_LAST = K'(N - 1);

    logic [DW-1:0] mem [0:2*N-1];

    logic [K-1:0]  wr_cnt_q;
    logic          wr_bank_q;
    logic [K-1:0]  rd_cnt_q;
    logic          rd_bank_q;
    logic [1:0]    full_q;
    logic [1:0]    full_d;
    logic [DW-1:0] s1_data_q;
    logic          s1_valid_q;
    logic          s1_last_q;
    logic [DW-1:0] data_q;
    logic          valid_q;
    logic          last_q;

    logic [K-1:0]  wr_rev;
    logic          wr_en;
    logic          advance;
    logic          issue;

    for (genvar gi = 0; gi < K; gi++) begin : g_rev
        assign wr_rev[gi] = wr_cnt_q[K-1-gi];
    end

    assign ready_o = ~full_q[wr_bank_q];
    assign wr_en   = valid_i && ready_o;
    // The RAM read register and the output register move together as one stalling pipeline.
    assign advance = ~valid_q || ready_i;
    assign issue   = full_q[rd_bank_q] && advance;

    always_comb begin
        full_d = full_q;
        if (wr_en && (wr_cnt_q == CNT_LAST)) begin
            full_d[wr_bank_q] = 1'b1;
        end
        if (issue && (rd_cnt_q == CNT_LAST)) begin
            full_d[rd_bank_q] = 1'b0;
        end
    end

    // Storage and its registered read port carry no reset so they map onto block RAM.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[{wr_bank_q, wr_rev}] <= data_i;
        end
        if (issue) begin
            s1_data_q <= mem[{rd_bank_q, rd_cnt_q}];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_cnt_q   <= '0;
            wr_bank_q  <= 1'b0;
            rd_cnt_q   <= '0;
            rd_bank_q  <= 1'b0;
            full_q     <= 2'b00;
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            full_q <= full_d;
            if (wr_en) begin
                wr_cnt_q <= wr_cnt_q + K'(1);
                if (wr_cnt_q == CNT_LAST) begin
                    wr_bank_q <= ~wr_bank_q;
                end
            end
            if (issue) begin
                rd_cnt_q <= rd_cnt_q + K'(1);
                if (rd_cnt_q == CNT_LAST) begin
                    rd_bank_q <= ~rd_bank_q;
                end
            end
            if (advance) begin
                s1_valid_q <= issue;
                s1_last_q  <= (rd_cnt_q == CNT_LAST);
                valid_q    <= s1_valid_q;
                if (s1_valid_q) begin
                    data_q <= s1_data_q;
                    last_q <= s1_last_q;
                end
            end
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

`ifdef BITREV_UNSCR_LAST_EN
    assign last_o = last_q;
`else
    logic unused_last;
    assign unused_last = last_q ^ s1_last_q;
`endif

endmodule

// File: tb/tb_bitrev_unscramble.sv
// Self-checking bench for bitrev_unscramble (K=3): directed frames, backpressure, random flow control, reset.
module tb_bitrev_unscramble;
    localparam int K  = 3;
    localparam int DW = 16;
    localparam int N  = 1 << K;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          valid_i = 1'b0;
    logic          ready_i = 1'b0;
    logic [DW-1:0] data_i = '0;
    logic          ready_o;
    logic          valid_o;
    logic [DW-1:0] data_o;
`ifdef BITREV_UNSCR_LAST_EN
    logic          last_o;
`endif

    bitrev_unscramble #(.K(K), .DW(DW)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .valid_i (valid_i),
        .data_i  (data_i),
        .ready_o (ready_o),
        .valid_o (valid_o),
        .data_o  (data_o),
        .ready_i (ready_i)
`ifdef BITREV_UNSCR_LAST_EN
        ,
        .last_o  (last_o)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int edge_cnt = 0;
    int last_acc_edge = 0;
    int accepts = 0;
    int outputs = 0;
    logic [DW-1:0] frame_buf[$];
    logic [DW-1:0] exp_q[$];
    bit            exp_last_q[$];
    bit            prev_stall = 0;
    logic [DW-1:0] prev_data = '0;
    bit            prev_last = 0;
    int            ord[8] = '{0, 4, 2, 6, 1, 5, 3, 7};

    function automatic int bitrev(input int x);
        int r = 0;
        for (int i = 0; i < K; i++) begin
            if (((x >> i) & 1) != 0) r = r | (1 << (K - 1 - i));
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Arrival slot j of a frame carries natural index bitrev(j), so natural n sits in slot bitrev(n).
    task automatic model_accept(input logic [DW-1:0] d);
        frame_buf.push_back(d);
        if (frame_buf.size() == N) begin
            for (int n = 0; n < N; n++) begin
                exp_q.push_back(frame_buf[bitrev(n)]);
                exp_last_q.push_back(n == N - 1);
            end
            frame_buf.delete();
        end
    endtask

    // Called at a falling edge: observe outputs, update model, drive inputs, advance one cycle.
    task automatic step(input bit v, input bit r, input logic [DW-1:0] d, input bit rst);
        bit acc;
        bit pop;
        logic [DW-1:0] e;
        bit el;
        if (rst) begin
            rst_n = 1'b0; valid_i = v; ready_i = r; data_i = d;
            @(posedge clk); edge_cnt++;
            @(negedge clk);
            rst_n = 1'b1;
            frame_buf.delete(); exp_q.delete(); exp_last_q.delete();
            prev_stall = 0;
            $display("step edge=%0d reset", edge_cnt);
            return;
        end
        if (prev_stall) begin
            check("hold_valid", 32'(valid_o), 32'd1);
            check("hold_data", 32'(data_o), 32'(prev_data));
`ifdef BITREV_UNSCR_LAST_EN
            check("hold_last", 32'(last_o), 32'(prev_last));
`endif
        end
        acc = v && ready_o;
        pop = valid_o && r;
        if (pop) begin
            check("out_avail", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                el = exp_last_q.pop_front();
                check("data", 32'(data_o), 32'(e));
`ifdef BITREV_UNSCR_LAST_EN
                check("last", 32'(last_o), 32'(el));
`endif
            end
            outputs++;
            $display("step edge=%0d out data=%0h", edge_cnt, data_o);
        end
        prev_stall = valid_o && !r;
        prev_data  = data_o;
`ifdef BITREV_UNSCR_LAST_EN
        prev_last  = last_o;
`endif
        if (acc) begin
            model_accept(d);
            accepts++;
            last_acc_edge = edge_cnt + 1;
            $display("step edge=%0d in data=%0h", edge_cnt + 1, d);
        end
        valid_i = v; ready_i = r; data_i = d;
        @(posedge clk); edge_cnt++;
        @(negedge clk);
    endtask

    task automatic directed_frame(input int base, input string tag);
        for (int i = 0; i < N; i++) step(1'b1, 1'b1, DW'(base + i), 1'b0);
        for (int c = 0; c < 10 && !valid_o; c++) step(1'b0, 1'b1, '0, 1'b0);
        check({tag, "_latency"}, 32'(edge_cnt - last_acc_edge), 32'd2);
        for (int i = 0; i < N; i++) begin
            check({tag, "_valid"}, 32'(valid_o), 32'd1);
            check({tag, "_order"}, 32'(data_o), 32'(base + ord[i]));
`ifdef BITREV_UNSCR_LAST_EN
            check({tag, "_last"}, 32'(last_o), 32'(i == N - 1));
`endif
            step(1'b0, 1'b1, '0, 1'b0);
        end
        check({tag, "_idle"}, 32'(valid_o), 32'd0);
    endtask

    initial begin
        bit seen;
        int nchk;
        @(negedge clk);
        step(1'b0, 1'b0, '0, 1'b1);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_data", 32'(data_o), 32'd0);
        check("rst_ready", 32'(ready_o), 32'd1);
`ifdef BITREV_UNSCR_LAST_EN
        check("rst_last", 32'(last_o), 32'd0);
`endif

        // One frame, back-to-back, no backpressure.
        directed_frame(0, "s1");

        // Backpressure until both banks fill.
        accepts = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 16) check("s2_ready_low", 32'(ready_o), 32'd0);
            step(1'b1, 1'b0, DW'($urandom), 1'b0);
        end
        check("s2_accepts", 32'(accepts), 32'd16);
        outputs = 0;
        for (int c = 0; c < 100 && exp_q.size() > 0; c++) step(1'b0, 1'b1, '0, 1'b0);
        check("s2_drained", 32'(outputs), 32'd16);
        check("s2_ready_back", 32'(ready_o), 32'd1);
        check("s2_valid_idle", 32'(valid_o), 32'd0);

        // Four continuous frames: no input stalls, no output bubbles.
        accepts = 0; outputs = 0; seen = 0; nchk = 0;
        for (int i = 0; i < 46; i++) begin
            if (valid_o) seen = 1;
            if (seen && nchk < 32) begin
                check("s3_no_bubble", 32'(valid_o), 32'd1);
                nchk++;
            end
            step(i < 32, 1'b1, DW'($urandom), 1'b0);
        end
        check("s3_accepts", 32'(accepts), 32'd32);
        check("s3_outputs", 32'(outputs), 32'd32);

        // Random flow control on both sides.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), DW'($urandom), 1'b0);
        end
        for (int c = 0; c < 200 && exp_q.size() > 0; c++) step(1'b0, 1'b1, '0, 1'b0);
        check("s4_drained", 32'(exp_q.size()), 32'd0);
        for (int c = 0; c < 4; c++) step(1'b0, 1'b1, '0, 1'b0);
        check("s4_idle", 32'(valid_o), 32'd0);

        // Partial frame discarded by reset.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, DW'(100 + i), 1'b0);
        step(1'b0, 1'b1, '0, 1'b1);
        check("s5_rst_valid", 32'(valid_o), 32'd0);
        check("s5_rst_data", 32'(data_o), 32'd0);
        check("s5_rst_ready", 32'(ready_o), 32'd1);
        directed_frame(16'h10, "s5");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
